spi_shift_engine: RTL and testbench
===================================

# spi_shift_engine

Serial shift engine for the SPI-style peripheral, directly downstream of the input conditioners. It consumes the conditioned chip-select, the serial-clock edge pulses and conditioned MOSI, deserialises MSB-first frames into parallel words, and serialises a buffered transmit word onto MISO. All activity is in the single system clock domain; the serial clock is never used as a clock.

## Interface
- width, default 8: frame length in bits (legal ≥ 2).
- countwidth, default 3: bit-counter width; must satisfy 2^countwidth ≥ width.
- clk, in, 1: system clock; everything updates on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- cs_n, in, 1: conditioned chip select, active low.
- sclk_pos, in, 1: one-clk pulse at each rising edge of the conditioned serial clock.
- sclk_neg, in, 1: one-clk pulse at each falling edge of the conditioned serial clock.
- mosi, in, 1: conditioned serial data in.
- tx_data, in, width: word to transmit.
- tx_load, in, 1: writes tx_data into the transmit buffer when tx_ready = 1.
- tx_ready, out, 1: transmit buffer empty.
- rx_data, out, width: last complete received frame.
- rx_valid, out, 1: one-clk pulse when rx_data updates.
- miso, out, 1: serial data out.
- miso_en, out, 1: MISO drive enable (tri-state control for the top level).

## Operation
- States: IDLE, ACTIVE. IDLE→ACTIVE when cs_n = 0; ACTIVE→IDLE when cs_n = 1. No other transitions.
- Transmit buffer: width bits plus full flag. tx_ready = !full. tx_load while full is ignored, and the buffer is not overwritten.
- Buffer consumption ("load tx_shift"): tx_shift ← buffer if full, otherwise all zeros; full clears.
- IDLE→ACTIVE entry: bitcnt ← 0, rx_shift ← 0, load tx_shift, reload_pend ← 0.
- ACTIVE, sclk_pos:
  - rx_shift ← {rx_shift[width-2:0], mosi}.
  - bitcnt increments, except at bitcnt = width-1, where it wraps to 0.
  - At wrap: rx_data ← {rx_shift[width-2:0], mosi}, rx_valid = 1, reload_pend ← 1.
- ACTIVE, sclk_neg:
  - If reload_pend = 1: load tx_shift and clear reload_pend.
  - Otherwise: tx_shift ← {tx_shift[width-2:0], 0}.
- miso = tx_shift[width-1] in ACTIVE, 0 in IDLE. miso_en = 1 exactly in ACTIVE.
- Frames are back-to-back while cs_n stays low. The counter wraps with no gap cycle.
- Boundary and priority rules:
  - sclk_pos and sclk_neg in the same cycle: sclk_pos is processed and sclk_neg is ignored.
  - cs_n rising with sclk_pos in the same cycle: abort wins. No shift, no rx_valid.
  - cs_n rising mid-frame: go to IDLE. Partial bits are discarded, rx_data is kept, bitcnt ← 0, reload_pend ← 0. An already-loaded tx_shift is lost; the buffer is untouched.
  - Edge pulses in IDLE are ignored.
  - tx_load in the same cycle as a buffer consumption: consumption sees the old contents; the new word is accepted only if the buffer was empty before that cycle.
- Reset, all registered outputs:
  - state = IDLE, rx_data = 0, rx_valid = 0, tx_ready = 1, miso = 0, miso_en = 0.
  - bitcnt = 0, tx_shift = 0, rx_shift = 0, buffer empty, reload_pend = 0.
  - Reset overrides every other input in that cycle.

## Timing
- All outputs are registered. A change caused by inputs sampled at edge N is visible after edge N.
- cs_n falling at edge N:
  - miso_en = 1 and miso = MSB of the loaded word after edge N.
  - This is mode 0: the first bit is valid before the first sclk_pos.
- The width-th sclk_pos sampled at edge N gives rx_valid = 1 and the new rx_data after edge N.
  - rx_valid drops after edge N+1.
  - rx_data holds until the next completed frame.
- tx_load sampled at edge N gives tx_ready = 0 after edge N. Consumption at edge M gives tx_ready = 1 after edge M.
- The sclk_neg that follows a completed frame presents the MSB of the next word on miso after that edge.
- Throughput: one bit per sclk_pos/sclk_neg pair. Minimum spacing between edge pulses is 1 clk.

## Test plan
- Reset with random inputs: all outputs at reset values. tx_ready = 1, miso_en = 0.
- Preload tx_data = 0xA5, drop cs_n, send MOSI 0x3C MSB-first over 8 pulse pairs:
  - miso sequence is 1,0,1,0,0,1,0,1.
  - rx_valid pulses once with rx_data = 0x3C.
  - tx_ready = 1 after cs_n falls.
- Two back-to-back frames with cs_n held low, buffer reloaded with 0x0F between frames:
  - Second frame's miso = 0x0F, with reload at the first sclk_neg after frame 1.
  - Receive 0x81 then 0x7E, with two rx_valid pulses.
- Frame with empty buffer: miso stays 0 for all 8 bits, miso_en = 1 throughout.
- Raise cs_n after 5 sclk_pos: no rx_valid, and rx_data keeps its previous value. A following full frame 0xC3 receives correctly.
- Collisions:
  - tx_load while tx_ready = 0: buffer is not overwritten.
  - sclk_pos and sclk_neg together: only the receive shift happens.
  - cs_n rise together with the 8th sclk_pos: no rx_valid.

Source files
------------

// File: rtl/spi_shift_engine.sv
// Serial shift engine: deserialises MSB-first MOSI frames into parallel words and
// serialises a buffered transmit word onto MISO, driven by serial-clock edge pulses.
module spi_shift_engine #(
  parameter int width      = 8,
  parameter int countwidth = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cs_n_i,
  input  logic             sclk_pos_i,
  input  logic             sclk_neg_i,
  input  logic             mosi_i,
  input  logic [width-1:0] tx_data_i,
  input  logic             tx_load_i,
  output logic             tx_ready_o,
  output logic [width-1:0] rx_data_o,
  output logic             rx_valid_o,
  output logic             miso_o,
  output logic             miso_en_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [countwidth-1:0] LAST_BIT = countwidth'(width - 1);
  localparam logic [countwidth-1:0] ONE      = countwidth'(1);

  state_t                state_q, state_d;
  logic [countwidth-1:0] bitcnt_q, bitcnt_d;
  logic [width-1:0]      rx_shift_q, rx_shift_d;
  logic [width-1:0]      tx_shift_q, tx_shift_d;
  logic [width-1:0]      tx_buf_q, tx_buf_d;
  logic                  tx_full_q, tx_full_d;
  logic                  reload_pend_q, reload_pend_d;
  logic [width-1:0]      rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  consume;
  logic [width-1:0]      rx_next;

  assign rx_next = {rx_shift_q[width-2:0], mosi_i};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      bitcnt_q      <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      tx_buf_q      <= '0;
      tx_full_q     <= 1'b0;
      reload_pend_q <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      bitcnt_q      <= bitcnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      tx_buf_q      <= tx_buf_d;
      tx_full_q     <= tx_full_d;
      reload_pend_q <= reload_pend_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    reload_pend_d = reload_pend_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    consume       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!cs_n_i) begin
          state_d       = ACTIVE;
          bitcnt_d      = '0;
          rx_shift_d    = '0;
          reload_pend_d = 1'b0;
          consume       = 1'b1;
        end
      end
      ACTIVE: begin
        // Deselect wins over any edge pulse in the same cycle.
        if (cs_n_i) begin
          state_d       = IDLE;
          bitcnt_d      = '0;
          rx_shift_d    = '0;
          tx_shift_d    = '0;
          reload_pend_d = 1'b0;
        end else if (sclk_pos_i) begin
          rx_shift_d = rx_next;
          if (bitcnt_q == LAST_BIT) begin
            bitcnt_d      = '0;
            rx_data_d     = rx_next;
            rx_valid_d    = 1'b1;
            reload_pend_d = 1'b1;
          end else begin
            bitcnt_d = bitcnt_q + ONE;
          end
        end else if (sclk_neg_i) begin
          if (reload_pend_q) begin
            consume       = 1'b1;
            reload_pend_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[width-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (consume) begin
      tx_shift_d = tx_full_q ? tx_buf_q : '0;
    end
  end

  // Buffer: consumption sees the pre-cycle contents; a load only lands if the
  // buffer was empty going into this cycle.
  always_comb begin
    tx_buf_d  = tx_buf_q;
    tx_full_d = tx_full_q;
    if (consume) begin
      tx_full_d = 1'b0;
    end
    if (tx_load_i && !tx_full_q) begin
      tx_buf_d  = tx_data_i;
      tx_full_d = 1'b1;
    end
  end

  assign tx_ready_o = !tx_full_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign miso_en_o  = (state_q == ACTIVE);
  assign miso_o     = (state_q == ACTIVE) && tx_shift_q[width-1];

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine; received words are checked through a
// scoreboard queue filled when each frame is driven.
module tb_spi_shift_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs_n;
  logic       sclk_pos;
  logic       sclk_neg;
  logic       mosi;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       miso;
  logic       miso_en;

  int total = 0;
  int bad   = 0;
  int rx_count = 0;
  logic [7:0] sb_q[$];

  spi_shift_engine #(.width(8), .countwidth(3)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .cs_n_i     (cs_n),
    .sclk_pos_i (sclk_pos),
    .sclk_neg_i (sclk_neg),
    .mosi_i     (mosi),
    .tx_data_i  (tx_data),
    .tx_load_i  (tx_load),
    .tx_ready_o (tx_ready),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .miso_o     (miso),
    .miso_en_o  (miso_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after an active edge; outputs sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always begin
    @(posedge clk);
    #1;
    if (rx_valid === 1'b1) begin
      rx_count++;
      if (sb_q.size() == 0) begin
        chk("unexpected_rx_valid", {24'd0, rx_data}, 32'hFFFF_FFFF);
      end else begin
        chk("rx_word", {24'd0, rx_data}, {24'd0, sb_q.pop_front()});
      end
    end
  end

  task automatic bits(input logic [7:0] rxw, input logic [7:0] txw, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      chk($sformatf("miso_bit%0d", i), {31'd0, miso}, {31'd0, txw[i]});
      chk("miso_en_active", {31'd0, miso_en}, 32'd1);
      sclk_pos = 1'b1;
      mosi     = rxw[i];
      step();
      sclk_pos = 1'b0;
      sclk_neg = 1'b1;
      step();
      sclk_neg = 1'b0;
    end
  endtask

  task automatic load_word(input logic [7:0] w);
    tx_data = w;
    tx_load = 1'b1;
    step();
    tx_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    cs_n = 1'b1; sclk_pos = 1'b0; sclk_neg = 1'b0; mosi = 1'b0;
    tx_data = 8'h00; tx_load = 1'b0;
    #1;
    // Reset with random inputs
    for (int k = 0; k < 4; k++) begin
      cs_n = 1'($urandom); sclk_pos = 1'($urandom); sclk_neg = 1'($urandom);
      mosi = 1'($urandom); tx_data = 8'($urandom); tx_load = 1'($urandom);
      step();
      chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
      chk("rst_miso_en", {31'd0, miso_en}, 32'd0);
      chk("rst_miso", {31'd0, miso}, 32'd0);
      chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    end
    cs_n = 1'b1; sclk_pos = 1'b0; sclk_neg = 1'b0; tx_load = 1'b0; mosi = 1'b0;
    reset = 1'b0;
    step();

    // Basic frame: tx A5, rx 3C
    load_word(8'hA5);
    chk("ready_after_load", {31'd0, tx_ready}, 32'd0);
    cs_n = 1'b0;
    step();
    chk("ready_after_cs", {31'd0, tx_ready}, 32'd1);
    chk("miso_en_after_cs", {31'd0, miso_en}, 32'd1);
    sb_q.push_back(8'h3C);
    bits(8'h3C, 8'hA5, 7, 0);
    chk("rx_valid_dropped", {31'd0, rx_valid}, 32'd0);
    chk("rx_data_held", {24'd0, rx_data}, 32'h3C);
    cs_n = 1'b1;
    step();
    chk("miso_en_idle", {31'd0, miso_en}, 32'd0);
    chk("miso_idle", {31'd0, miso}, 32'd0);

    // Back-to-back frames, reload 0F mid-frame
    load_word(8'hF0);
    cs_n = 1'b0;
    step();
    load_word(8'h0F);
    chk("ready_refilled", {31'd0, tx_ready}, 32'd0);
    sb_q.push_back(8'h81);
    sb_q.push_back(8'h7E);
    bits(8'h81, 8'hF0, 7, 0);
    chk("ready_after_reload", {31'd0, tx_ready}, 32'd1);
    bits(8'h7E, 8'h0F, 7, 0);
    cs_n = 1'b1;
    step();

    // Empty buffer frame
    cs_n = 1'b0;
    step();
    sb_q.push_back(8'h55);
    bits(8'h55, 8'h00, 7, 0);
    cs_n = 1'b1;
    step();

    // Abort after 5 bits, then full frame C3
    load_word(8'h96);
    cs_n = 1'b0;
    step();
    bits(8'hFF, 8'h96, 7, 3);
    cs_n = 1'b1;
    step();
    chk("abort_miso_en", {31'd0, miso_en}, 32'd0);
    chk("abort_rx_kept", {24'd0, rx_data}, 32'h55);
    chk("abort_buf_untouched", {31'd0, tx_ready}, 32'd1);
    cs_n = 1'b0;
    step();
    sb_q.push_back(8'hC3);
    bits(8'hC3, 8'h00, 7, 0);
    cs_n = 1'b1;
    step();

    // tx_load while full is ignored
    load_word(8'h11);
    load_word(8'h22);
    chk("ready_still_full", {31'd0, tx_ready}, 32'd0);
    cs_n = 1'b0;
    step();
    sb_q.push_back(8'h00);
    bits(8'h00, 8'h11, 7, 0);
    cs_n = 1'b1;
    step();

    // sclk_pos and sclk_neg together: receive only
    load_word(8'h80);
    cs_n = 1'b0;
    step();
    sb_q.push_back(8'hAB);
    chk("both_pre_miso", {31'd0, miso}, 32'd1);
    sclk_pos = 1'b1; sclk_neg = 1'b1; mosi = 1'b1;
    step();
    sclk_pos = 1'b0; sclk_neg = 1'b0;
    chk("both_no_tx_shift", {31'd0, miso}, 32'd1);
    sclk_neg = 1'b1;
    step();
    sclk_neg = 1'b0;
    chk("neg_shifted", {31'd0, miso}, 32'd0);
    bits(8'hAB, 8'h80, 6, 0);
    cs_n = 1'b1;
    step();

    // cs_n rise with 8th sclk_pos: aborted
    cs_n = 1'b0;
    step();
    bits(8'h5A, 8'h00, 7, 1);
    cs_n = 1'b1; sclk_pos = 1'b1; mosi = 1'b0;
    step();
    sclk_pos = 1'b0;
    chk("abort8_rx_valid", {31'd0, rx_valid}, 32'd0);
    step();
    chk("abort8_rx_kept", {24'd0, rx_data}, 32'hAB);
    chk("abort8_miso_en", {31'd0, miso_en}, 32'd0);

    step();
    step();
    chk("sb_drained", sb_q.size(), 32'd0);
    chk("rx_pulse_count", rx_count, 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
